uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
UART receiver for the core's MMIO UART block. It is the receive-side counterpart of the existing uart_tx.
- Oversamples the asynchronous rx pin at the system clock.
- Deframes 8N1 characters, LSB first.
- Buffers received bytes in a small show-ahead FIFO, which the UART MMIO logic drains through a valid/ready handshake.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
CLK_FREQ, 27000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate; CYCLE = CLK_FREQ/BAUD_RATE clocks per bit (integer division; default 234), HALF = CYCLE/2
FIFO_DEPTH, 8, receive FIFO entries; must be a power of 2, >= 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
rx_data  output  8  FIFO head byte; valid only while rx_data_valid=1
rx_data_valid  output  1  FIFO non-empty
rx_data_ready  input  1  consumer pops the head on the cycle valid&&ready
rx_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: good byte dropped because FIFO full

Behaviour:
Reset:
- rx_data_valid=0, rx_count=0, frame_err=0, overrun=0, rx_data=0.
- FSM to IDLE; both synchronizer flops set to 1.
- Reset mid-frame discards the partial byte and all FIFO contents.

Synchronizer:
- 2-flop synchronizer on rx produces rxs; all sampling uses rxs.
- Pin-to-rxs latency is 2 clocks.

FSM (states IDLE, START, DATA, STOP, WAIT_HIGH; single counter cnt, bit index bidx 0..7, shift register sh):
- IDLE: when rxs==0, go to START with cnt=0.
- START: count to HALF-1, then sample rxs.
  - rxs==0: go to DATA, cnt=0, bidx=0.
  - rxs==1: glitch; return to IDLE, no pulses.
- DATA: count CYCLE clocks, then sample rxs into sh[bidx] (LSB first). After bidx==7 is sampled, go to STOP.
- STOP: count CYCLE clocks, then sample rxs.
  - rxs==1: push sh into the FIFO; go to IDLE.
  - rxs==0: pulse frame_err on the next cycle, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: remain until rxs==1, then go to IDLE. A line held low (break) therefore never produces bytes or repeated frame_err.
- Sample points relative to the cycle T at which IDLE sees rxs==0:
  - start check at T+HALF
  - bit i at T+HALF+(i+1)*CYCLE
  - stop at T+HALF+9*CYCLE
- Back-to-back frames: IDLE is re-entered right after the stop sample (mid-stop-bit). A start edge immediately following the stop bit is accepted.

FIFO:
- Show-ahead: rx_data is combinationally the head entry.
- Push is the stop-good event; rx_data_valid rises the clock after the stop sample (1-cycle latency).
- Pop occurs when rx_data_valid && rx_data_ready. Ready while empty is ignored.
- Push and pop in the same cycle: count unchanged, both take effect, including when full.
- Push while full with no pop: byte dropped, overrun pulses for 1 cycle, FIFO contents unchanged.
- Pointers wrap modulo FIFO_DEPTH. rx_count is registered and goes 0..FIFO_DEPTH.
- frame_err and overrun are never high for more than one consecutive cycle per event.

Test Plan:
All scenarios use CLK_FREQ=16, BAUD_RATE=1 (CYCLE=16, HALF=8) and FIFO_DEPTH=8 unless stated.
1. Single byte: send 0x5A (8N1, LSB first), rx_data_ready=0 -> rx_data_valid rises exactly HALF+9*CYCLE+1 clocks after rxs falls; rx_data=0x5A, rx_count=1. Ready pulsed one cycle -> valid=0, count=0.
2. Glitch: drive rx low for 3 clocks, then high -> no byte, no frame_err, FSM back in IDLE; a following 0xA5 frame is received correctly.
3. Framing error: send 0x33 with stop bit=0, then hold rx low for 100 clocks -> exactly one frame_err pulse, rx_count stays 0. Release rx high and send 0x81 -> 0x81 received.
4. Overrun: send 9 bytes 0x00..0x08 with ready=0 -> rx_count=8, one overrun pulse on the 9th. Drain -> 0x00..0x07 in order, valid=0 afterwards.
5. Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap, ready tied 1 -> bytes popped in order, each valid for exactly 1 cycle, no error pulses.
6. Reset mid-frame: assert rst for 1 clock during bit 4 of 0x77 with 2 bytes already queued -> all outputs return to reset values. The next complete 0x3C frame yields rx_count=1, rx_data=0x3C.
7. Simultaneous push/pop with FIFO full (8 queued) and ready=1 on the stop-sample cycle -> count stays 8, no overrun, new byte appears at the tail.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a show-ahead receive FIFO.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   rx            asynchronous serial line, idle high
//   rx_data       FIFO head byte (0 while the FIFO is empty)
//   rx_data_valid FIFO non-empty
//   rx_data_ready consumer pops the head when valid && ready
//   rx_count      FIFO occupancy, 0..FIFO_DEPTH
//   frame_err     one-cycle pulse: stop bit sampled low
//   overrun       one-cycle pulse: good byte dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 27000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic [7:0]                  rx_data,
    output logic                        rx_data_valid,
    input  logic                        rx_data_ready,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    output logic                        frame_err,
    output logic                        overrun
);

    localparam int unsigned CYCLE = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF  = CYCLE / 2;
    localparam int unsigned CNT_W = $clog2(CYCLE + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CYCLE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_t;

    // Synchronizer
    logic r_sync1;
    logic r_sync2;
    logic w_rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // Deframer
    state_t           r_state;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [2:0]       r_bidx;
    logic [2:0]       w_bidx_d;
    logic [7:0]       r_sh;
    logic [7:0]       w_sh_d;
    logic             w_push;
    logic             w_ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_bidx  <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_bidx  <= w_bidx_d;
            r_sh    <= w_sh_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + 1'b1;
        w_bidx_d  = r_bidx;
        w_sh_d    = r_sh;
        w_push    = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (!w_rxs) begin
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_d   = '0;
                    w_bidx_d  = '0;
                    // A start bit that is gone by mid-bit is treated as a glitch.
                    w_state_d = w_rxs ? StIdle : StData;
                end
            end
            StData: begin
                if (r_cnt == CNT_BIT) begin
                    w_cnt_d        = '0;
                    w_sh_d[r_bidx] = w_rxs;
                    w_bidx_d       = r_bidx + 3'd1;
                    if (r_bidx == 3'd7) begin
                        w_state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (r_cnt == CNT_BIT) begin
                    w_cnt_d = '0;
                    if (w_rxs) begin
                        w_push    = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_ferr    = 1'b1;
                        w_state_d = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                // Swallow a held-low line (break) until it returns to idle.
                w_cnt_d = '0;
                if (w_rxs) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Receive FIFO
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;

    assign w_full = (r_count == CNT_FULL);
    assign w_pop  = rx_data_valid && rx_data_ready;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= w_push && w_full && !w_pop;
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign rx_data_valid = (r_count != '0);
    assign rx_data       = rx_data_valid ? r_mem[r_rptr] : 8'h00;
    assign rx_count      = r_count;
    assign frame_err     = r_frame_err;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames, a queue-based model checked every cycle,
// plus literal expectations for each scenario.
module tb_uart_rx_fifo;

    localparam int CYCLE = 16;
    localparam int HALF  = 8;
    localparam int DEPTH = 8;
    // Pin drive cycle of the start bit -> cycle of the stop-bit sample (2 sync clocks).
    localparam int SAMPLE_OFS = 2 + HALF + 9 * CYCLE;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic [3:0] rx_count;
    logic       frame_err;
    logic       overrun;

    uart_rx_fifo #(
        .CLK_FREQ  (16),
        .BAUD_RATE (1),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .rx_count     (rx_count),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: expected FIFO contents plus events scheduled by the stimulus.
    logic [7:0] mq [$];
    bit   [7:0] push_sched [int];
    bit         ferr_sched [int];
    bit         exp_ferr = 1'b0;
    bit         exp_ovr  = 1'b0;
    bit         chk_en   = 1'b0;

    int         ferr_seen  = 0;
    int         ovr_seen   = 0;
    int         valid_seen = 0;
    int         last_rise  = -1;
    logic       prev_valid = 1'b0;
    logic [7:0] pop_log [$];

    always @(negedge clk) begin
        bit         m_valid;
        logic [7:0] m_data;
        bit         m_pop;
        bit         m_full;
        if (chk_en) begin
            m_valid = (mq.size() != 0);
            m_data  = m_valid ? mq[0] : 8'h00;
            check("rx_count", 32'(rx_count), 32'(mq.size()));
            check("rx_data_valid", 32'(rx_data_valid), 32'(m_valid));
            check("rx_data", 32'(rx_data), 32'(m_data));
            check("frame_err", 32'(frame_err), 32'(exp_ferr));
            check("overrun", 32'(overrun), 32'(exp_ovr));

            if (frame_err === 1'b1) ferr_seen++;
            if (overrun === 1'b1) ovr_seen++;
            if (rx_data_valid === 1'b1) valid_seen++;
            if (rx_data_valid === 1'b1 && prev_valid === 1'b0) last_rise = cyc;
            prev_valid = rx_data_valid;

            if (rst) begin
                mq.delete();
                push_sched.delete();
                ferr_sched.delete();
                exp_ferr = 1'b0;
                exp_ovr  = 1'b0;
            end else begin
                m_pop    = m_valid && (rx_data_ready === 1'b1);
                m_full   = (mq.size() == DEPTH);
                exp_ferr = ferr_sched.exists(cyc);
                exp_ovr  = 1'b0;
                if (m_pop) begin
                    pop_log.push_back(mq[0]);
                    void'(mq.pop_front());
                end
                if (push_sched.exists(cyc)) begin
                    if (m_full && !m_pop) exp_ovr = 1'b1;
                    else mq.push_back(push_sched[cyc]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, output int p);
        p = cyc;
        if (stop) push_sched[p + SAMPLE_OFS] = b;
        else ferr_sched[p + SAMPLE_OFS] = 1'b1;
        rx = 1'b0;
        repeat (CYCLE) step();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CYCLE) step();
        end
        rx = stop;
        repeat (CYCLE) step();
    endtask

    task automatic pop_one();
        rx_data_ready = 1'b1;
        step();
        rx_data_ready = 1'b0;
        step();
    endtask

    int p;
    int f0;
    int o0;
    int v0;
    int b0;
    logic [7:0] pb;

    initial begin
        rst           = 1'b1;
        rx            = 1'b1;
        rx_data_ready = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        check("reset_count", 32'(rx_count), 32'd0);
        check("reset_valid", 32'(rx_data_valid), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        step();
        rst = 1'b0;
        repeat (20) step();

        // 1: single byte and its latency
        send_byte(8'h5A, 1'b1, p);
        repeat (4) step();
        check("t1_latency", 32'(last_rise - (p + 2)), 32'd153);
        check("t1_data", 32'(rx_data), 32'h5A);
        check("t1_count", 32'(rx_count), 32'd1);
        pop_one();
        check("t1_valid_after_pop", 32'(rx_data_valid), 32'd0);
        repeat (10) step();

        // 2: glitch, then a good frame
        f0 = ferr_seen;
        rx = 1'b0;
        repeat (3) step();
        rx = 1'b1;
        repeat (30) step();
        check("t2_glitch_count", 32'(rx_count), 32'd0);
        send_byte(8'hA5, 1'b1, p);
        repeat (10) step();
        check("t2_data", 32'(rx_data), 32'hA5);
        check("t2_no_ferr", 32'(ferr_seen - f0), 32'd0);
        pop_one();
        repeat (10) step();

        // 3: framing error followed by a break
        f0 = ferr_seen;
        send_byte(8'h33, 1'b0, p);
        repeat (100) step();
        rx = 1'b1;
        repeat (40) step();
        check("t3_ferr_pulses", 32'(ferr_seen - f0), 32'd1);
        check("t3_count", 32'(rx_count), 32'd0);
        send_byte(8'h81, 1'b1, p);
        repeat (10) step();
        check("t3_data", 32'(rx_data), 32'h81);
        pop_one();
        repeat (10) step();

        // 4: overrun on the ninth byte
        o0 = ovr_seen;
        for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1, p);
        repeat (5) step();
        check("t4_count", 32'(rx_count), 32'd8);
        check("t4_ovr_pulses", 32'(ovr_seen - o0), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("t4_drain", 32'(rx_data), 32'(i));
            pop_one();
        end
        check("t4_empty", 32'(rx_data_valid), 32'd0);
        repeat (10) step();

        // 5: back-to-back frames with ready held high
        f0 = ferr_seen;
        o0 = ovr_seen;
        v0 = valid_seen;
        b0 = pop_log.size();
        rx_data_ready = 1'b1;
        send_byte(8'h00, 1'b1, p);
        send_byte(8'hFF, 1'b1, p);
        send_byte(8'h55, 1'b1, p);
        repeat (20) step();
        rx_data_ready = 1'b0;
        check("t5_valid_cycles", 32'(valid_seen - v0), 32'd3);
        check("t5_pops", 32'(pop_log.size() - b0), 32'd3);
        check("t5_byte0", 32'(pop_log[b0]), 32'h00);
        check("t5_byte1", 32'(pop_log[b0 + 1]), 32'hFF);
        check("t5_byte2", 32'(pop_log[b0 + 2]), 32'h55);
        check("t5_no_err", 32'((ferr_seen - f0) + (ovr_seen - o0)), 32'd0);
        repeat (10) step();

        // 6: reset during bit 4 of 0x77 with two bytes queued
        send_byte(8'h11, 1'b1, p);
        send_byte(8'h22, 1'b1, p);
        repeat (5) step();
        check("t6_preload", 32'(rx_count), 32'd2);
        pb = 8'h77;
        rx = 1'b0;
        repeat (CYCLE) step();
        for (int i = 0; i < 4; i++) begin
            rx = pb[i];
            repeat (CYCLE) step();
        end
        rx = pb[4];
        repeat (HALF) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_count", 32'(rx_count), 32'd0);
        check("t6_rst_valid", 32'(rx_data_valid), 32'd0);
        check("t6_rst_data", 32'(rx_data), 32'd0);
        rx = 1'b1;
        repeat (200) step();
        send_byte(8'h3C, 1'b1, p);
        repeat (10) step();
        check("t6_count", 32'(rx_count), 32'd1);
        check("t6_data", 32'(rx_data), 32'h3C);
        pop_one();
        repeat (10) step();

        // 7: push and pop together while full
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1, p);
        o0 = ovr_seen;
        fork
            send_byte(8'h99, 1'b1, p);
            begin
                repeat (SAMPLE_OFS) step();
                rx_data_ready = 1'b1;
                step();
                rx_data_ready = 1'b0;
            end
        join
        repeat (5) step();
        check("t7_count", 32'(rx_count), 32'd8);
        check("t7_no_ovr", 32'(ovr_seen - o0), 32'd0);
        for (int i = 1; i < 8; i++) begin
            check("t7_drain", 32'(rx_data), 32'h10 + 32'(i));
            pop_one();
        end
        check("t7_tail", 32'(rx_data), 32'h99);
        pop_one();
        check("t7_empty", 32'(rx_data_valid), 32'd0);
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
